// File: rtl/clock_set_ctrl_if.sv
// Button / live-time / shadow-time bundle between the set controller and its neighbours.
// master = front-end side (buttons, live time in); slave = the set controller.
interface clock_set_ctrl_if;
   logic       btn_mode;
   logic       btn_inc;
   logic       btn_dec;
   logic       btn_cancel;

   logic [3:0] cur_sec_unit,   cur_sec_ten;
   logic [3:0] cur_min_unit,   cur_min_ten;
   logic [3:0] cur_hour_unit,  cur_hour_ten;
   logic [3:0] cur_day_unit;
   logic [1:0] cur_day_ten;
   logic [3:0] cur_month_unit;
   logic [1:0] cur_month_ten;
   logic [3:0] cur_year_unit,  cur_year_ten, cur_year_hund, cur_year_thou;

   logic [3:0] set_sec_unit,   set_sec_ten;
   logic [3:0] set_min_unit,   set_min_ten;
   logic [3:0] set_hour_unit,  set_hour_ten;
   logic [3:0] set_day_unit;
   logic [1:0] set_day_ten;
   logic [3:0] set_month_unit;
   logic [1:0] set_month_ten;
   logic [3:0] set_year_unit,  set_year_ten, set_year_hund, set_year_thou;

   logic       load;
   logic       run_en;
   logic [2:0] edit_field;
   logic       blink;

   modport master (
      output btn_mode, btn_inc, btn_dec, btn_cancel,
      output cur_sec_unit, cur_sec_ten, cur_min_unit, cur_min_ten,
             cur_hour_unit, cur_hour_ten, cur_day_unit, cur_day_ten,
             cur_month_unit, cur_month_ten,
             cur_year_unit, cur_year_ten, cur_year_hund, cur_year_thou,
      input  set_sec_unit, set_sec_ten, set_min_unit, set_min_ten,
             set_hour_unit, set_hour_ten, set_day_unit, set_day_ten,
             set_month_unit, set_month_ten,
             set_year_unit, set_year_ten, set_year_hund, set_year_thou,
      input  load, run_en, edit_field, blink
   );

   modport slave (
      input  btn_mode, btn_inc, btn_dec, btn_cancel,
      input  cur_sec_unit, cur_sec_ten, cur_min_unit, cur_min_ten,
             cur_hour_unit, cur_hour_ten, cur_day_unit, cur_day_ten,
             cur_month_unit, cur_month_ten,
             cur_year_unit, cur_year_ten, cur_year_hund, cur_year_thou,
      output set_sec_unit, set_sec_ten, set_min_unit, set_min_ten,
             set_hour_unit, set_hour_ten, set_day_unit, set_day_ten,
             set_month_unit, set_month_ten,
             set_year_unit, set_year_ten, set_year_hund, set_year_thou,
      output load, run_en, edit_field, blink
   );
endinterface

// File: rtl/clock_set_ctrl.sv
// Time/date setting controller: walks the user through Y/MO/D/H/MI/S in a BCD shadow
// register, holds the counters while editing and issues a one-cycle parallel load.
module clock_set_ctrl #(
   parameter int unsigned BLINK_DIV = 50000000
) (
   input logic             clk,
   input logic             rst,
   clock_set_ctrl_if.slave bus
);
   localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   // Field states share their encoding with edit_field.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_YEAR   = 3'd1,
      S_MONTH  = 3'd2,
      S_DAY    = 3'd3,
      S_HOUR   = 3'd4,
      S_MIN    = 3'd5,
      S_SEC    = 3'd6,
      S_COMMIT = 3'd7
   } state_t;

   state_t           state, state_nxt;
   logic [15:0]      yr, yr_nxt;
   logic [5:0]       mo, mo_nxt, dy, dy_nxt, dim_nxt;
   logic [7:0]       hr, hr_nxt, mi, mi_nxt, se, se_nxt;
   logic             adj, up, field_active;
   logic [CNT_W-1:0] blink_cnt;
   logic             blink_q;

   function automatic logic div4(input logic [7:0] v);
      return ((6'(v[7:4]) * 6'd2 + 6'(v[3:0])) % 6'd4) == 6'd0;
   endfunction

   function automatic logic is_leap(input logic [15:0] y);
      return (y[7:0] == 8'h00) ? div4(y[15:8]) : div4(y[7:0]);
   endfunction

   function automatic logic [5:0] dim(input logic [5:0] m, input logic [15:0] y);
      case (m)
         6'h04, 6'h06, 6'h09, 6'h11: return 6'h30;
         6'h02:                      return is_leap(y) ? 6'h29 : 6'h28;
         default:                    return 6'h31;
      endcase
   endfunction

   // Two-digit BCD step with wrap between lo and hi (both BCD).
   function automatic logic [7:0] bcd2_step(input logic [7:0] v, input logic [7:0] lo,
                                            input logic [7:0] hi, input logic inc);
      if (inc) begin
         if (v >= hi)          return lo;
         if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
         return {v[7:4], v[3:0] + 4'd1};
      end
      if (v <= lo)             return hi;
      if (v[3:0] == 4'd0)      return {v[7:4] - 4'd1, 4'd9};
      return {v[7:4], v[3:0] - 4'd1};
   endfunction

   function automatic logic [15:0] year_step(input logic [15:0] y, input logic inc);
      logic [15:0] r;
      logic        carry;
      r     = y;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (inc) begin
               if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
               else begin r[4*i +: 4] = r[4*i +: 4] + 4'd1; carry = 1'b0; end
            end else begin
               if (r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
               else begin r[4*i +: 4] = r[4*i +: 4] - 4'd1; carry = 1'b0; end
            end
         end
      end
      return r;
   endfunction

   assign field_active = (state != S_IDLE) && (state != S_COMMIT);
   assign up           = bus.btn_inc;

   // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
   always_comb begin
      state_nxt = state;
      yr_nxt    = yr;
      mo_nxt    = mo;
      dy_nxt    = dy;
      hr_nxt    = hr;
      mi_nxt    = mi;
      se_nxt    = se;
      adj       = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.btn_mode) begin
               yr_nxt    = {bus.cur_year_thou, bus.cur_year_hund, bus.cur_year_ten, bus.cur_year_unit};
               mo_nxt    = {bus.cur_month_ten, bus.cur_month_unit};
               dy_nxt    = {bus.cur_day_ten, bus.cur_day_unit};
               hr_nxt    = {bus.cur_hour_ten, bus.cur_hour_unit};
               mi_nxt    = {bus.cur_min_ten, bus.cur_min_unit};
               se_nxt    = {bus.cur_sec_ten, bus.cur_sec_unit};
               state_nxt = S_YEAR;
            end
         end
         S_COMMIT: state_nxt = S_IDLE;
         default: begin
            if (bus.btn_cancel) begin
               state_nxt = S_IDLE;
            end else if (bus.btn_mode) begin
               state_nxt = state_t'(state + 3'd1);
            end else if (bus.btn_inc ^ bus.btn_dec) begin
               adj = 1'b1;
               case (state)
                  S_YEAR:  yr_nxt = year_step(yr, up);
                  S_MONTH: mo_nxt = 6'(bcd2_step({2'b00, mo}, 8'h01, 8'h12, up));
                  S_DAY:   dy_nxt = 6'(bcd2_step({2'b00, dy}, 8'h01, {2'b00, dim(mo, yr)}, up));
                  S_HOUR:  hr_nxt = bcd2_step(hr, 8'h00, 8'h23, up);
                  S_MIN:   mi_nxt = bcd2_step(mi, 8'h00, 8'h59, up);
                  S_SEC:   se_nxt = bcd2_step(se, 8'h00, 8'h59, up);
                  default: ;
               endcase
            end
         end
      endcase
      // Day clamp covers year/month edits and the entry snapshot alike.
      dim_nxt = dim(mo_nxt, yr_nxt);
      if (dy_nxt > dim_nxt) dy_nxt = dim_nxt;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         yr        <= 16'h0000;
         mo        <= 6'h01;
         dy        <= 6'h01;
         hr        <= 8'h00;
         mi        <= 8'h00;
         se        <= 8'h00;
         blink_cnt <= '0;
         blink_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         yr    <= yr_nxt;
         mo    <= mo_nxt;
         dy    <= dy_nxt;
         hr    <= hr_nxt;
         mi    <= mi_nxt;
         se    <= se_nxt;
         if (state_nxt == S_IDLE || adj) begin
            blink_cnt <= '0;
            blink_q   <= 1'b0;
         end else if (field_active) begin
            if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
               blink_cnt <= '0;
               blink_q   <= ~blink_q;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end
      end
   end

   assign bus.run_en         = (state == S_IDLE);
   assign bus.load           = (state == S_COMMIT);
   assign bus.edit_field     = field_active ? state : 3'd0;
   assign bus.blink          = blink_q;

   assign bus.set_year_thou  = yr[15:12];
   assign bus.set_year_hund  = yr[11:8];
   assign bus.set_year_ten   = yr[7:4];
   assign bus.set_year_unit  = yr[3:0];
   assign bus.set_month_ten  = mo[5:4];
   assign bus.set_month_unit = mo[3:0];
   assign bus.set_day_ten    = dy[5:4];
   assign bus.set_day_unit   = dy[3:0];
   assign bus.set_hour_ten   = hr[7:4];
   assign bus.set_hour_unit  = hr[3:0];
   assign bus.set_min_ten    = mi[7:4];
   assign bus.set_min_unit   = mi[3:0];
   assign bus.set_sec_ten    = se[7:4];
   assign bus.set_sec_unit   = se[3:0];
endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Time/date setting controller for the century clock.
- Sequences the user through editing year, month, day, hour, minute and second fields in a shadow register.
- Holds the clock counters while editing, then issues a one-cycle parallel load of the edited BCD value into the counter chain.
- Sits between the debounced button front-end and the century clock counters.

Parameters:
- BLINK_DIV, 50000000: clock cycles per half-period of the blink output.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- btn_mode  in  1  one-cycle pulse: advance to next field
- btn_inc  in  1  one-cycle pulse: increment current field
- btn_dec  in  1  one-cycle pulse: decrement current field
- btn_cancel  in  1  one-cycle pulse: abort editing, no load
- cur_sec_unit, cur_sec_ten, cur_min_unit, cur_min_ten, cur_hour_unit, cur_hour_ten  in  4 each  live clock time (BCD)
- cur_day_unit  in  4;  cur_day_ten  in  2;  cur_month_unit  in  4;  cur_month_ten  in  2  live date (BCD)
- cur_year_unit, cur_year_ten, cur_year_hund, cur_year_thou  in  4 each  live year (BCD)
- set_* (same 14 fields, same widths, prefix set_)  out  shadow values presented to the counters
- load  out  1  one-cycle strobe: counters load set_* this edge
- run_en  out  1  1 = counters run; 0 = counters held
- edit_field  out  3  0 idle, 1 year, 2 month, 3 day, 4 hour, 5 min, 6 sec
- blink  out  1  square wave for the active field display; 0 when idle

Behaviour:
- Reset values:
  - state IDLE; run_en=1; load=0; edit_field=0; blink=0; blink counter=0.
  - set_* = 0000-01-01 00:00:00, i.e. day_unit=1, month_unit=1, all other fields 0.
- States: IDLE -> Y -> MO -> D -> H -> MI -> S -> COMMIT -> IDLE.
- IDLE:
  - btn_mode: snapshot all cur_* into the shadow, go to Y.
  - run_en=0 and edit_field=1 from the next cycle.
  - btn_inc, btn_dec and btn_cancel are ignored.
- Y/MO/D/H/MI/S:
  - btn_mode advances to the next state.
  - btn_inc/btn_dec adjust only the active field; the result appears on set_* the next cycle.
- Priority within one cycle: cancel > mode > inc/dec.
  - mode with inc: the inc is dropped.
  - inc and dec in the same cycle: both ignored.
- Cancel: go to IDLE; run_en=1 next cycle; load stays 0; shadow retained but not loaded.
- COMMIT: exactly one cycle with load=1, run_en=0, set_* stable. Next cycle IDLE, run_en=1, load=0.
- Field ranges (wrap both directions):
  - year 0000..9999, BCD 4-digit carry/borrow, 9999+1=0000, 0000-1=9999.
  - month 1..12.
  - day 1..dim(month, year).
  - hour 0..23; minute 0..59; second 0..59.
- All arithmetic stays in BCD; no shadow digit ever holds A..F.
- dim: 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11; February is 29 if leap, else 28.
- Leap rule: (y%4==0 and y%100!=0) or y%400==0, on the 4-digit year.
- Day clamp:
  - Any change to year or month that makes day > dim clamps day to dim in the same update cycle.
  - The snapshot is also clamped on entry.
- Blink:
  - Counter runs only while edit_field != 0 and toggles blink every BLINK_DIV cycles.
  - Counter and blink reset to 0 on entering IDLE and on every inc/dec, so the field stays visible while adjusting.
- rst asserted in any state returns to reset values on that edge; no load is issued.
- Latency from button pulse to output update: 1 cycle.

Test Plan:
- Reset, then btn_mode with cur = 2023-12-31 23:59:59 -> edit_field=1, run_en=0, set_* equals the snapshot.
- In Y, btn_inc from 2023 -> 2024; btn_dec from 0000 -> 9999.
- Snapshot 2024-02-29, btn_inc on year -> 2025, set day clamps to 28.
- Set 2000-02, in D btn_dec from 01 -> 29. Set 1900-02 -> D wraps to 28.
- In MO, 12 +1 -> 01. In H, 00 -1 -> 23. In S, 59 +1 -> 00.
- Full cycle of 7 mode presses -> load high exactly one cycle with the edited values, then run_en=1.
- btn_cancel mid-edit -> IDLE, run_en=1, no load pulse.
- btn_mode and btn_inc in the same cycle -> field advances, value unchanged.
